div_unit: RTL and testbench
===========================

# div_unit

Iterative radix-2 restoring integer divider serving the LoongArch `div.w`, `div.wu`, `mod.w` and `mod.wu` instructions. It is the inverse counterpart of the Booth multiplier path in the execute stage. It accepts one 32-bit operand pair over a valid/ready handshake and returns the quotient and remainder together 32 iteration cycles later. It holds its result under back-pressure and is abortable by a pipeline flush.

## Interface
No parameters; the operand width is fixed at 32.
- `clk`  in  1  sole clock; all state updates on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `flush`  in  1  abort the in-flight operation; takes priority over everything else
- `in_valid`  in  1  operand pair presented
- `in_ready`  out  1  divider can accept; equals (state==IDLE)
- `dividend`  in  32  dividend, sampled on acceptance
- `divisor`  in  32  divisor, sampled on acceptance
- `is_signed`  in  1  1 = two's-complement (`div.w`/`mod.w`), 0 = unsigned
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer takes the result
- `quotient`  out  32  quotient, sign-corrected
- `remainder`  out  32  remainder, sign-corrected

## Operation
States: IDLE, CALC, DONE.
- **Acceptance:** occurs in IDLE when `in_valid` is 1 and `flush` is 0.
- **Register capture on acceptance:**
  - magnitude |dividend| and |divisor|; magnitude is the input when `is_signed`=0 or the MSB is 0, otherwise the 32-bit two's-complement negation;
  - q_neg = is_signed & (dividend[31] ^ divisor[31]);
  - r_neg = is_signed & dividend[31];
  - original dividend, for the divide-by-zero result;
  - 6-bit iteration counter cleared to 0.
- **Divide by zero (divisor==0 on acceptance):** go straight to DONE. quotient = 0xFFFFFFFF and remainder = the original dividend, for both signed and unsigned.
- **Otherwise:** go to CALC.
- **CALC, one step per cycle:**
  - 33-bit partial remainder R (init 0) and 32-bit quotient register Q (init |dividend|).
  - Shift {R,Q} left by 1, then compute T = R − |divisor|.
  - If T ≥ 0, then R = T and Q[0] = 1; otherwise keep R and set Q[0] = 0.
  - Counter increments each step. After the 32nd step (counter==31), go to DONE.
- **DONE:** latch quotient = q_neg ? −Q : Q and remainder = r_neg ? −R[31:0] : R[31:0] into the output registers.
  - `out_valid`=1 while in DONE.
  - Outputs are held stable until `out_ready`=1, then return to IDLE.
  - No same-cycle re-accept, because `in_ready`=0 in DONE.
- **Signed overflow (0x80000000 / 0xFFFFFFFF, signed):** needs no special path. Q = 0x80000000 with q_neg=0, giving quotient 0x80000000 and remainder 0.
- **Sign rule:** the remainder takes the sign of the dividend; a zero magnitude stays zero after negation.
- **Flush:** `flush`=1 in any state forces IDLE at the next edge.
  - `out_valid` falls on that edge; the result is discarded.
  - A `flush` coincident with `in_valid` in IDLE suppresses acceptance.

## Timing
- **Reset values (sync, `rst_n`=0 at an edge):**
  - state=IDLE, so `in_ready`=1 from the cycle after reset;
  - `out_valid`=0; quotient=0; remainder=0; counter=0; R and Q = 0.
  - Reset mid-operation discards all work identically.
- **Normal latency:** acceptance in cycle 0, iterations at the ends of cycles 1–32, `out_valid`=1 from cycle 33. Throughput is one operation per ≥34 cycles.
- **Divide-by-zero latency:** `out_valid`=1 in cycle 1.
- **`in_ready`:** combinational from state only; it does not depend on `in_valid`.
- **Inputs after acceptance:** `dividend`, `divisor` and `is_signed` are don't-care once accepted.
- **Result hand-off:** a result is consumed on an edge where `out_valid` and `out_ready` are both 1. The earliest next acceptance is the following cycle.
- **Stability:** `quotient` and `remainder` are registered and stable for the whole time `out_valid` is high. Their values outside DONE are unspecified to the consumer, but they are never X after reset.

## Test plan
- Unsigned 100 / 7 -> `out_valid` in cycle 33, quotient 0x0000000E, remainder 0x00000002; `in_ready`=0 during cycles 1–33.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 0x00000001 -> quotient 0xFFFFFFFF, remainder 0.
- Divisor 0 with dividend 0x12345678, signed and unsigned -> `out_valid` in cycle 1, quotient 0xFFFFFFFF, remainder 0x12345678.
- `out_ready` held 0 for 10 cycles after `out_valid` rises -> outputs and `out_valid` stable throughout. Then `out_ready`=1 for one cycle -> IDLE next cycle, and a new op accepted the cycle after gives the correct result.
- `flush` at cycle 15 of an operation -> `out_valid` never rises, `in_ready`=1 next cycle. `flush` together with `in_valid` in IDLE -> no acceptance. `rst_n`=0 at cycle 20 -> all outputs at their reset values next cycle.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring 32-bit divider for div.w/div.wu/mod.w/mod.wu.
// Signed operands are divided as magnitudes; the signs are restored when the result is latched.
module div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [32:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] dvsr_r;
  logic        q_neg_r;
  logic        r_neg_r;
  logic [5:0]  cnt_r;
  logic        out_valid_r;
  logic [31:0] quotient_r;
  logic [31:0] remainder_r;

  logic [32:0] shift_s;
  logic [33:0] sub_s;
  logic        fits_s;
  logic [32:0] rem_next_s;
  logic [31:0] quo_next_s;

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
    if (sgn && v[31]) begin
      magnitude = 32'd0 - v;
    end else begin
      magnitude = v;
    end
  endfunction

  function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
    if (neg) begin
      apply_sign = 32'd0 - v;
    end else begin
      apply_sign = v;
    end
  endfunction

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;

  // One restoring step: shift {R,Q} left, trial-subtract the divisor, keep it if non-negative
  always_comb begin
    shift_s    = {rem_r[31:0], quo_r[31]};
    sub_s      = {1'b0, shift_s} - {2'b00, dvsr_r};
    fits_s     = rem_r[32] | ~sub_s[33];
    rem_next_s = shift_s;
    quo_next_s = {quo_r[30:0], 1'b0};
    if (fits_s) begin
      rem_next_s = sub_s[32:0];
      quo_next_s = {quo_r[30:0], 1'b1};
    end else begin
      rem_next_s = shift_s;
      quo_next_s = {quo_r[30:0], 1'b0};
    end
  end

  // Control FSM, datapath registers and registered results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rem_r       <= 33'd0;
      quo_r       <= 32'd0;
      dvsr_r      <= 32'd0;
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      cnt_r       <= 6'd0;
      out_valid_r <= 1'b0;
      quotient_r  <= 32'd0;
      remainder_r <= 32'd0;
    end else if (flush) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            rem_r   <= 33'd0;
            quo_r   <= magnitude(dividend, is_signed);
            dvsr_r  <= magnitude(divisor, is_signed);
            q_neg_r <= is_signed & (dividend[31] ^ divisor[31]);
            r_neg_r <= is_signed & dividend[31];
            cnt_r   <= 6'd0;
            if (divisor == 32'd0) begin
              // Divide by zero bypasses iteration: all-ones quotient, dividend as remainder
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              quotient_r  <= 32'hFFFF_FFFF;
              remainder_r <= dividend;
            end else begin
              state_r <= CALC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          cnt_r <= cnt_r + 6'd1;
          if (cnt_r == 6'd31) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            quotient_r  <= apply_sign(quo_next_s, q_neg_r);
            remainder_r <= apply_sign(rem_next_s[31:0], r_neg_r);
          end else begin
            state_r <= CALC;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed corner cases plus random operands
// checked against a plain-arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  div_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: language-level division on widened operands
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sg);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) begin
      return {32'hFFFF_FFFF, a};
    end
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      return {q[31:0], r[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {uq, ur};
  endfunction

  // Drive point: a little after the rising edge, away from sampling at the falling edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Monitor: pops the scoreboard on every consumed result
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%h_%h expected=none", quotient, remainder);
      end else begin
        e = exp_q.pop_front();
        chk("quotient", quotient, e[63:32]);
        chk("remainder", remainder, e[31:0]);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 60) begin
      tick();
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sg, input int hold);
    int cyc;
    int busy_bad;
    int unstable;
    logic [31:0] q0, r0;
    wait_ready();
    exp_q.push_back(model(a, b, sg));
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = sg;
    tick();
    in_valid  = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom_range(0, 1));
    cyc = 0;
    busy_bad = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (in_ready) busy_bad++;
      if (out_valid) break;
    end
    chk("latency", cyc, (b == 32'd0) ? 32'd1 : 32'd33);
    chk("in_ready_busy", busy_bad, 32'd0);
    q0 = quotient;
    r0 = remainder;
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!out_valid || quotient !== q0 || remainder !== r0) unstable++;
    end
    chk("hold_stable", unstable, 32'd0);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_after_handoff", {31'd0, in_ready}, 32'd1);
    chk("valid_after_handoff", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
  endtask

  initial begin
    int seen;
    logic [31:0] a, b;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    is_signed = 1'b0;
    do_reset();

    do_op(32'd100, 32'd7, 1'b0, 10);
    do_op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 0);
    do_op(32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 1);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 2);
    do_op(32'h1234_5678, 32'h0000_0000, 1'b1, 0);
    do_op(32'h1234_5678, 32'h0000_0000, 1'b0, 3);
    do_op(32'h0000_0000, 32'h8000_0000, 1'b1, 0);

    // Flush mid-operation: no result may appear
    wait_ready();
    in_valid = 1'b1; dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 15; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_no_valid", seen, 32'd0);

    // Flush coincident with in_valid suppresses acceptance
    tick();
    in_valid = 1'b1; flush = 1'b1; dividend = 32'h1234_5678; divisor = 32'd0;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_accept_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("flush_accept_valid", {31'd0, out_valid}, 32'd0);

    do_op(32'd77, 32'd5, 1'b0, 0);

    // Reset in cycle 20 of an operation
    wait_ready();
    in_valid = 1'b1; dividend = 32'hDEAD_BEEF; divisor = 32'd9; is_signed = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    do_reset();
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_no_valid", seen, 32'd0);

    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 255);
        2: b = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
        default: b = $urandom;
      endcase
      do_op(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
